mux_sel_sequencer: RTL and testbench



---
 rtl/mux_sel_sequencer_if.sv | 39 +++
 rtl/mux_sel_sequencer.sv | 102 ++++++++++
 tb/tb_mux_sel_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_sequencer_if.sv
// Handshake and mux-drive bundle between the word source, the select
// sequencer and the consumer of the serial mux output.
interface mux_sel_sequencer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_ready;
  logic [7:0] word_o;
  logic [2:0] sel_o;
  logic       bit_valid_o;
  logic       last_o;
  logic       busy_o;

  // Word source / bit consumer side
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  word_o,
    input  sel_o,
    input  bit_valid_o,
    input  last_o,
    input  busy_o
  );

  // Sequencer side
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output word_o,
    output sel_o,
    output bit_valid_o,
    output last_o,
    output busy_o
  );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Select sequencer for an 8-to-1 bit mux: latches one word per handshake,
// then walks the select through all eight bit positions, one per accepted
// output beat. A new word can be taken on the final beat so consecutive
// words stream without a bubble.
module mux_sel_sequencer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  mux_sel_sequencer_if.slave bus
);

  localparam logic [2:0] FIRST = LSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [2:0] FINAL = LSB_FIRST ? 3'd7 : 3'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state_r;
  logic   final_s;
  logic   ready_s;

  // Next bit position in the configured walking direction.
  function automatic logic [2:0] step_sel(input logic [2:0] sel);
    if (LSB_FIRST) begin
      return sel + 3'd1;
    end else begin
      return sel - 3'd1;
    end
  endfunction

  assign final_s = (bus.sel_o == FINAL);

  // Accept window: always open when idle, otherwise only as the final beat drains.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      IDLE:    ready_s = 1'b1;
      SHIFT:   ready_s = final_s && bus.out_ready;
      default: ready_s = 1'b0;
    endcase
  end

  // Reset closes the window immediately, independent of the registered state.
  assign bus.in_ready = rst_n && ready_s;

  // Sequencer FSM with registered word, select and beat qualifiers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      bus.word_o      <= 8'h00;
      bus.sel_o       <= FIRST;
      bus.bit_valid_o <= 1'b0;
      bus.last_o      <= 1'b0;
      bus.busy_o      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            state_r         <= SHIFT;
            bus.word_o      <= bus.in_data;
            bus.sel_o       <= FIRST;
            bus.bit_valid_o <= 1'b1;
            bus.busy_o      <= 1'b1;
            bus.last_o      <= 1'b0;
          end
        end
        SHIFT: begin
          // A stalled beat holds word, select and all qualifiers.
          if (bus.out_ready) begin
            if (final_s) begin
              bus.sel_o  <= FIRST;
              bus.last_o <= 1'b0;
              if (bus.in_valid) begin
                // Back-to-back reload: stay in SHIFT with no idle beat.
                bus.word_o <= bus.in_data;
              end else begin
                // Word keeps its last value while idle.
                state_r         <= IDLE;
                bus.bit_valid_o <= 1'b0;
                bus.busy_o      <= 1'b0;
              end
            end else begin
              bus.sel_o  <= step_sel(bus.sel_o);
              bus.last_o <= (step_sel(bus.sel_o) == FINAL);
            end
          end
        end
        default: begin
          state_r         <= IDLE;
          bus.sel_o       <= FIRST;
          bus.bit_valid_o <= 1'b0;
          bus.last_o      <= 1'b0;
          bus.busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Self-checking bench: an LSB-first and an MSB-first sequencer share the
// same stimulus and are compared every cycle against a beat-count model.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: word in flight and number of completed beats.
  bit         act_m;
  int         cnt_m;
  logic [7:0] word_m;

  always #5 clk = ~clk;

  mux_sel_sequencer_if ifa ();
  mux_sel_sequencer_if ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.out_ready = out_ready;

  mux_sel_sequencer #(.LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mux_sel_sequencer #(.LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // Expected outputs from the model; sel follows from beat count and direction.
  function automatic logic [15:0] exp_vec(input bit lsb);
    logic [2:0] c;
    logic [2:0] s;
    logic       ir;
    c  = cnt_m[2:0];
    s  = act_m ? (lsb ? c : 3'd7 - c) : (lsb ? 3'd0 : 3'd7);
    ir = rst_n && (!act_m || (cnt_m == 7 && out_ready));
    return {ir, word_m, s, act_m, act_m && (cnt_m == 7), act_m, word_m[s]};
  endfunction

  function automatic logic [31:0] exp_all();
    return {exp_vec(1'b1), exp_vec(1'b0)};
  endfunction

  function automatic logic [31:0] obs_all();
    return {ifa.in_ready, ifa.word_o, ifa.sel_o, ifa.bit_valid_o, ifa.last_o, ifa.busy_o,
            ifa.word_o[ifa.sel_o],
            ifb.in_ready, ifb.word_o, ifb.sel_o, ifb.bit_valid_o, ifb.last_o, ifb.busy_o,
            ifb.word_o[ifb.sel_o]};
  endfunction

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      act_m = 1'b0; cnt_m = 0; word_m = 8'h00;
    end else if (!act_m) begin
      if (in_valid) begin
        act_m = 1'b1; cnt_m = 0; word_m = in_data;
      end
    end else if (out_ready) begin
      if (cnt_m == 7) begin
        cnt_m = 0;
        if (in_valid) word_m = in_data;
        else act_m = 1'b0;
      end else begin
        cnt_m = cnt_m + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_run++;
      if (obs_all() !== exp_all()) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got %h want %h", i, obs_all(), exp_all());
      end
      n_run++;
      if (ifa.in_ready !== 1'b0 || ifa.word_o !== 8'h00 || ifb.sel_o !== 3'd7) begin
        n_fail++;
        $display("FAIL reset_const cyc %0d: got rdy=%b word=%h selb=%0d want 0/00/7",
                 i, ifa.in_ready, ifa.word_o, ifb.sel_o);
      end
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    n_run++;
    if (obs_all() !== exp_all() || ifa.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", obs_all(), exp_all());
    end
    tick();
  endtask

  // Send one word with out_ready high and check the LSB-first bit stream.
  task automatic send_word_lsb(input logic [7:0] w, input string name);
    in_valid = 1'b1; in_data = w; out_ready = 1'b1;
    #1;
    n_run++;
    if (obs_all() !== exp_all()) begin
      n_fail++;
      $display("FAIL %s_accept: got %h want %h", name, obs_all(), exp_all());
    end
    tick();
    in_valid = 1'b0; in_data = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      #1;
      n_run++;
      if (obs_all() !== exp_all()) begin
        n_fail++;
        $display("FAIL %s beat %0d: got %h want %h", name, i, obs_all(), exp_all());
      end
      n_run++;
      if (ifa.word_o[ifa.sel_o] !== w[i] || ifa.sel_o !== 3'(i) ||
          ifa.last_o !== (i == 7) || ifa.bit_valid_o !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_stream beat %0d: got bit=%b sel=%0d last=%b want bit=%b sel=%0d last=%b",
                 name, i, ifa.word_o[ifa.sel_o], ifa.sel_o, ifa.last_o, w[i], i, (i == 7));
      end
      tick();
    end
    #1;
    n_run++;
    if (obs_all() !== exp_all() || ifa.in_ready !== 1'b1 || ifa.bit_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: got %h want %h", name, obs_all(), exp_all());
    end
  endtask

  task automatic test_single_word();
    send_word_lsb(8'hA5, "single");
    tick();
  endtask

  task automatic test_backpressure();
    int done  = 0;
    int stall = 0;
    int valid = 0;
    int cyc   = 0;
    logic [7:0] got = 8'h00;
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    while (done < 8 && cyc < 40) begin
      if ((done == 1 || done == 4) && stall < 3) begin
        out_ready = 1'b0; stall++;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      n_run++;
      if (obs_all() !== exp_all() || ifa.sel_o !== 3'(done)) begin
        n_fail++;
        $display("FAIL bp cyc %0d: got %h want %h sel=%0d", cyc, obs_all(), exp_all(), done);
      end
      if (ifa.bit_valid_o) valid++;
      if (out_ready && ifa.bit_valid_o) begin
        got[done] = ifa.word_o[ifa.sel_o];
        done++; stall = 0;
      end
      tick();
      cyc++;
    end
    n_run++;
    if (done != 8 || valid != 14 || got !== 8'h3C) begin
      n_fail++;
      $display("FAIL bp_totals: got beats=%0d valid=%0d bits=%h want 8/14/3c", done, valid, got);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    tick();
    in_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      in_valid = (i <= 7);
      #1;
      n_run++;
      if (obs_all() !== exp_all() || ifa.bit_valid_o !== 1'b1 ||
          ifa.word_o[ifa.sel_o] !== (i < 8) || (i == 7 && ifa.in_ready !== 1'b1)) begin
        n_fail++;
        $display("FAIL b2b cyc %0d: got %h want %h", i, obs_all(), exp_all());
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_run++;
    if (obs_all() !== exp_all() || ifa.bit_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got %h want %h", obs_all(), exp_all());
    end
  endtask

  task automatic test_msb_first();
    in_valid = 1'b1; in_data = 8'h80; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_run++;
      if (obs_all() !== exp_all()) begin
        n_fail++;
        $display("FAIL msb beat %0d: got %h want %h", i, obs_all(), exp_all());
      end
      n_run++;
      if (ifb.sel_o !== 3'(7 - i) || ifb.word_o[ifb.sel_o] !== (i == 0) ||
          ifb.last_o !== (i == 7)) begin
        n_fail++;
        $display("FAIL msb_stream beat %0d: got sel=%0d bit=%b last=%b want sel=%0d bit=%b last=%b",
                 i, ifb.sel_o, ifb.word_o[ifb.sel_o], ifb.last_o, 7 - i, (i == 0), (i == 7));
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1; in_data = 8'hF0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_run++;
      if (obs_all() !== exp_all()) begin
        n_fail++;
        $display("FAIL midrst beat %0d: got %h want %h", i, obs_all(), exp_all());
      end
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_run++;
    if (obs_all() !== exp_all() || ifa.bit_valid_o !== 1'b0 || ifa.sel_o !== 3'd0 ||
        ifb.sel_o !== 3'd7) begin
      n_fail++;
      $display("FAIL midrst_idle: got %h want %h", obs_all(), exp_all());
    end
    send_word_lsb(8'h0F, "after_rst");
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_run++;
      if (obs_all() !== exp_all()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", i, obs_all(), exp_all());
      end
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    act_m = 1'b0; cnt_m = 0; word_m = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_msb_first();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
